src_xfer_pacer: RTL and testbench
=================================

SRC_XFER_PACER -- requirements
Module: src_xfer_pacer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of payload and output bus.
REQ-002 Parameter FIFO_DEPTH, default 4, power of two >= 2, input buffer entries.
REQ-003 Parameter GAP_CYCLES, default 8, >= 2, minimum src-clock spacing between successive o_next_data_pulse assertions.
REQ-004 i_src_clk  input  1  source-domain clock; all logic on its rising edge.
REQ-005 i_src_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_flush  input  1  synchronous discard of all buffered, unissued words.
REQ-007 i_valid  input  1  upstream word present on i_data.
REQ-008 i_data  input  DATA_WIDTH  upstream payload.
REQ-009 o_ready  output  1  block accepts i_data this cycle.
REQ-010 o_next_data_pulse  output  1  single-cycle transfer strobe to the enable-based bus synchronizer.
REQ-011 o_src_data  output  DATA_WIDTH  payload for the synchronizer; valid in the strobe cycle.
REQ-012 o_busy  output  1  high when FIFO non-empty or gap counter non-zero.
REQ-013 o_level  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.

Function
REQ-014 Push occurs when i_valid && o_ready on a rising edge; o_ready = (level != FIFO_DEPTH) && !i_flush, combinational.
REQ-015 FSM states IDLE and GAP; GAP counter width $clog2(GAP_CYCLES).
REQ-016 IDLE: if level != 0 and !i_flush, pop head, register it to o_src_data, assert o_next_data_pulse next cycle, load counter GAP_CYCLES-1, go GAP.
REQ-017 GAP: counter decrements each cycle; at counter == 1 -> IDLE so the next strobe is exactly GAP_CYCLES cycles after the previous at full throughput.
REQ-018 o_next_data_pulse is registered, high exactly one cycle per popped word, never high in two cycles closer than GAP_CYCLES apart.
REQ-019 o_src_data holds the last issued word until the next strobe; it never changes outside a strobe cycle.
REQ-020 Latency: word pushed into empty FIFO in IDLE at edge n -> strobe high in cycle n+1 with that word on o_src_data.
REQ-021 Order preserved: words issued strictly in push order.
REQ-022 Simultaneous push and pop: level unchanged, both take effect; legal at level == FIFO_DEPTH only in the sense that the pop frees space next cycle (o_ready stays low this cycle).
REQ-023 Pointers wrap modulo FIFO_DEPTH; level saturates neither up nor down (full blocks push, empty blocks pop).
REQ-024 i_flush: level, read and write pointers cleared next edge; push that cycle ignored; no pop that cycle; GAP counter and o_src_data unaffected (an in-flight spacing still completes).
REQ-025 o_busy = (level != 0) || (state == GAP).

Reset
REQ-026 On i_src_rst_n low: state IDLE, counter 0, pointers 0, level 0, o_next_data_pulse 0, o_src_data 0, o_busy 0.
REQ-027 o_ready is 0 during reset and 1 in the first cycle after release (FIFO empty).
REQ-028 Reset mid-GAP or with FIFO non-empty discards all state; no strobe in the cycle following deassertion.
REQ-029 FIFO storage array is not reset; content is don't-care until written.

Structure
REQ-030 Shared package cdc_sync_pkg holds the FSM state enum (PACER_IDLE, PACER_GAP) and default constants for DATA_WIDTH, FIFO_DEPTH, GAP_CYCLES.
REQ-031 One sub-module src_pace_fifo (DATA_WIDTH, FIFO_DEPTH; push, pop, flush, head data, level) instantiated once; FSM and gap counter live in the top.
REQ-032 No logic on any destination clock; output feeds i_next_data_pulse/i_src_data of the synchronizer directly.

Verification
REQ-033 Reset release, push 0xA5A5_0001 at cycle 5 -> strobe in cycle 6, o_src_data 0xA5A5_0001, o_busy high until cycle 13.
REQ-034 Back-to-back push of 4 words, GAP_CYCLES=8 -> strobes at cycles t, t+8, t+16, t+24, words in order, o_ready low while level==4.
REQ-035 Push 5 words with i_valid held -> 5th accepted only after first pop, o_level never exceeds 4, no word lost or duplicated.
REQ-036 Assert i_flush with level 3 during GAP -> level 0 next cycle, no further strobes, o_src_data keeps last issued value, o_busy drops when counter expires.
REQ-037 Assert i_src_rst_n low mid-GAP with level 2 -> all outputs zero, no strobe after release until a new push.
REQ-038 End-to-end with enable_based bus synchronizer, dest clock 3x slower, GAP_CYCLES=8 -> every issued word appears on dest output in order, none skipped.

Source files
------------

// File: rtl/cdc_sync_pkg.sv
// Shared types and default sizing for the source-side transfer pacer and its
// enable-based bus synchronizer partner.
package cdc_sync_pkg;

  typedef enum logic {
    PACER_IDLE = 1'b0,
    PACER_GAP  = 1'b1
  } pacer_state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_GAP_CYCLES = 8;

endpackage

// File: rtl/src_pace_fifo.sv
// Small input buffer for the pacer: show-ahead head word, occupancy level, flush.
// Push is ignored when full, pop ignored when empty; flush beats both.
module src_pace_fifo
  import cdc_sync_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                                i_src_clk,
  input  logic                                i_src_rst_n,
  input  logic                                i_flush,
  input  logic                                i_push,
  input  logic [DATA_WIDTH-1:0]               i_push_data,
  input  logic                                i_pop,
  output logic [DATA_WIDTH-1:0]               o_head_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     o_level
);

  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;

  assign w_full  = (r_level == LW'(FIFO_DEPTH));
  assign w_empty = (r_level == '0);
  assign w_push  = i_push && !w_full && !i_flush;
  assign w_pop   = i_pop && !w_empty && !i_flush;

  // Storage is deliberately unreset; only written slots are ever read.
  always_ff @(posedge i_src_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge i_src_clk or negedge i_src_rst_n) begin
    if (!i_src_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_head_data = r_mem[r_rd_ptr];
  assign o_level     = r_level;

endmodule

// File: rtl/src_xfer_pacer.sv
// Buffers source words and issues them as single-cycle strobes spaced at least
// GAP_CYCLES apart; strobe one cycle after the pop decision, o_ready drops when full.
module src_xfer_pacer
  import cdc_sync_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic                            i_src_clk,
  input  logic                            i_src_rst_n,
  input  logic                            i_flush,
  input  logic                            i_valid,
  input  logic [DATA_WIDTH-1:0]           i_data,
  output logic                            o_ready,
  output logic                            o_next_data_pulse,
  output logic [DATA_WIDTH-1:0]           o_src_data,
  output logic                            o_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_level
);

  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int CW = $clog2(GAP_CYCLES);

  pacer_state_t          r_state;
  logic [CW-1:0]         r_cnt;
  logic                  r_pulse;
  logic [DATA_WIDTH-1:0] r_src_data;
  logic [LW-1:0]         w_level;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_push;
  logic                  w_pop;

  // Reset gating keeps upstream stalled while the block is held in reset.
  assign o_ready = i_src_rst_n && (w_level != LW'(FIFO_DEPTH)) && !i_flush;
  assign w_push  = i_valid && o_ready;
  assign w_pop   = (r_state == PACER_IDLE) && (w_level != '0) && !i_flush;

  src_pace_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_src_clk   (i_src_clk),
    .i_src_rst_n (i_src_rst_n),
    .i_flush     (i_flush),
    .i_push      (w_push),
    .i_push_data (i_data),
    .i_pop       (w_pop),
    .o_head_data (w_head),
    .o_level     (w_level)
  );

  // Leaving GAP at count 1 lets IDLE pop on the following edge, giving an
  // exact GAP_CYCLES strobe period when the buffer stays non-empty.
  always_ff @(posedge i_src_clk or negedge i_src_rst_n) begin
    if (!i_src_rst_n) begin
      r_state    <= PACER_IDLE;
      r_cnt      <= '0;
      r_pulse    <= 1'b0;
      r_src_data <= '0;
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        PACER_IDLE: begin
          if (w_pop) begin
            r_src_data <= w_head;
            r_pulse    <= 1'b1;
            r_cnt      <= CW'(GAP_CYCLES - 1);
            r_state    <= PACER_GAP;
          end
        end
        PACER_GAP: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_state <= PACER_IDLE;
          end
        end
        default: r_state <= PACER_IDLE;
      endcase
    end
  end

  assign o_next_data_pulse = r_pulse;
  assign o_src_data        = r_src_data;
  assign o_busy            = (w_level != '0) || (r_state == PACER_GAP);
  assign o_level           = w_level;

endmodule

// File: tb/tb_src_xfer_pacer.sv
// Scoreboarded bench for src_xfer_pacer, including a toggle-based slow-domain
// receiver that stands in for the enable-based bus synchronizer.
module tb_src_xfer_pacer;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int GAP   = 8;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk   = 1'b0;
  logic          dclk  = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          valid = 1'b0;
  logic [DW-1:0] data  = '0;
  logic          ready;
  logic          pulse;
  logic [DW-1:0] src_data;
  logic          busy;
  logic [LW-1:0] level;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_strobe = -1000;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] exp_q [$];
  int            stamp_q [$];
  logic [DW-1:0] d_q [$];
  logic          saw_full = 1'b0;

  src_xfer_pacer #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .GAP_CYCLES (GAP)
  ) dut (
    .i_src_clk         (clk),
    .i_src_rst_n       (rst_n),
    .i_flush           (flush),
    .i_valid           (valid),
    .i_data            (data),
    .o_ready           (ready),
    .o_next_data_pulse (pulse),
    .o_src_data        (src_data),
    .o_busy            (busy),
    .o_level           (level)
  );

  always #5 clk = ~clk;
  initial begin
    #2;
    forever #15 dclk = ~dclk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Slow-domain receiver: toggle on each strobe, two-flop sync, capture held word.
  logic tog = 1'b0, s1 = 1'b0, s2 = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tog <= 1'b0;
    else if (pulse) tog <= ~tog;
  end
  always @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= tog;
      s2 <= s1;
      if (s1 != s2) d_q.push_back(src_data);
    end
  end

  // Strobe monitor: order, spacing, and data stability between strobes.
  initial forever begin
    logic [DW-1:0] e;
    @(negedge clk);
    if (!rst_n) begin
      prev_data   = src_data;
      last_strobe = -1000;
    end else if (pulse) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL strobe_unexpected: got strobe with data %h, required no strobe", src_data);
      end else begin
        e = exp_q.pop_front();
        if (src_data !== e) begin
          n_fail++;
          $display("FAIL strobe_data: got %h, required %h", src_data, e);
        end
      end
      n_tests++;
      if (cyc - last_strobe < GAP) begin
        n_fail++;
        $display("FAIL strobe_spacing: got %0d cycles, required >= %0d", cyc - last_strobe, GAP);
      end
      last_strobe = cyc;
      stamp_q.push_back(cyc);
      prev_data = src_data;
    end else begin
      n_tests++;
      if (src_data !== prev_data) begin
        n_fail++;
        $display("FAIL data_hold: got %h, required %h", src_data, prev_data);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Holds i_valid with word d until accepted; returns just after the next falling edge.
  task automatic send(input logic [DW-1:0] d);
    logic acc;
    int k;
    valid = 1'b1;
    data  = d;
    for (k = 0; k < 100; k++) begin
      #1;
      acc = ready;
      n_tests++;
      if (level > DEPTH || (level == DEPTH && ready)) begin
        n_fail++;
        $display("FAIL level_bound: got level %0d ready %b, required level <= %0d and ready=0 when full", level, ready, DEPTH);
      end
      if (level == DEPTH && !ready) saw_full = 1'b1;
      @(posedge clk);
      if (acc) exp_q.push_back(d);
      @(negedge clk);
      if (acc) break;
    end
    if (k == 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: word %h got not accepted, required accepted within 100 cycles", d);
    end
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 400; k++) begin
      if (exp_q.size() == 0 && !busy) break;
      @(negedge clk);
    end
    n_tests++;
    if (k == 400) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d words pending busy %b, required 0 pending and idle", exp_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({pulse, src_data, busy, level, ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got pulse %b data %h busy %b level %0d ready %b, required all 0",
               pulse, src_data, busy, level, ready);
    end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_release: got %b, required 1", ready);
    end
    @(negedge clk);
    n_tests++;
    if (ready !== 1'b1 || busy !== 1'b0 || level !== '0 || pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_release: got ready %b busy %b level %0d pulse %b, required 1 0 0 0",
               ready, busy, level, pulse);
    end
  endtask

  task automatic test_single();
    int t0;
    send(32'hA5A5_0001);
    valid = 1'b0;
    n_tests++;
    if (pulse !== 1'b0 || level !== LW'(1) || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_push_cycle: got pulse %b level %0d busy %b, required 0 1 1", pulse, level, busy);
    end
    @(negedge clk);
    t0 = cyc;
    n_tests++;
    if (pulse !== 1'b1 || src_data !== 32'hA5A5_0001) begin
      n_fail++;
      $display("FAIL single_latency: got pulse %b data %h, required 1 a5a50001", pulse, src_data);
    end
    repeat (6) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_busy_hold: got %b at strobe+%0d, required 1", busy, cyc - t0);
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy_drop: got %b at strobe+%0d, required 0", busy, cyc - t0);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    stamp_q.delete();
    saw_full = 1'b0;
    for (int i = 0; i < 6; i++) send(32'hB000_0000 + DW'(i));
    valid = 1'b0;
    drain();
    n_tests++;
    if (stamp_q.size() != 6) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d strobes, required 6", stamp_q.size());
    end else begin
      for (int i = 1; i < 6; i++) begin
        n_tests++;
        if (stamp_q[i] - stamp_q[i-1] != GAP) begin
          n_fail++;
          $display("FAIL b2b_period: got %0d cycles, required %0d", stamp_q[i] - stamp_q[i-1], GAP);
        end
      end
    end
    n_tests++;
    if (saw_full !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_full_backpressure: got %b, required ready low seen at level %0d", saw_full, DEPTH);
    end
  endtask

  task automatic test_flush();
    int k;
    stamp_q.delete();
    for (int i = 1; i <= 4; i++) send(32'hC000_0000 + DW'(i));
    valid = 1'b0;
    n_tests++;
    if (level !== LW'(3) || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_setup: got level %0d busy %b, required 3 1", level, busy);
    end
    flush = 1'b1;
    #1;
    n_tests++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ready: got %b, required 0", ready);
    end
    @(posedge clk);
    exp_q.delete();
    @(negedge clk);
    flush = 1'b0;
    n_tests++;
    if (level !== '0 || src_data !== 32'hC000_0001 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_effect: got level %0d data %h busy %b, required 0 c0000001 1", level, src_data, busy);
    end
    for (k = 0; k < 20; k++) begin
      if (!busy) break;
      @(negedge clk);
    end
    n_tests++;
    if (k == 20 || stamp_q.size() == 0 || cyc - stamp_q[0] != GAP - 1) begin
      n_fail++;
      $display("FAIL flush_busy_drop: got busy %b strobes %0d, required busy 0 at strobe+%0d", busy, stamp_q.size(), GAP - 1);
    end
    repeat (20) @(negedge clk);
    n_tests++;
    if (stamp_q.size() != 1) begin
      n_fail++;
      $display("FAIL flush_no_strobe: got %0d strobes, required 1", stamp_q.size());
    end
  endtask

  task automatic test_reset_mid_gap();
    for (int i = 1; i <= 3; i++) send(32'hD000_0000 + DW'(i));
    valid = 1'b0;
    n_tests++;
    if (level !== LW'(2) || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_gap_setup: got level %0d busy %b, required 2 1", level, busy);
    end
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    n_tests++;
    if ({pulse, src_data, busy, level, ready} !== '0) begin
      n_fail++;
      $display("FAIL rst_gap_outputs: got pulse %b data %h busy %b level %0d ready %b, required all 0",
               pulse, src_data, busy, level, ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stamp_q.delete();
    repeat (25) @(negedge clk);
    n_tests++;
    if (stamp_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_gap_quiet: got %0d strobes busy %b, required 0 0", stamp_q.size(), busy);
    end
    send(32'hD000_0004);
    valid = 1'b0;
    drain();
    n_tests++;
    if (stamp_q.size() != 1) begin
      n_fail++;
      $display("FAIL rst_gap_resume: got %0d strobes, required 1", stamp_q.size());
    end
  endtask

  task automatic test_end_to_end();
    logic [DW-1:0] words [$];
    repeat (10) @(negedge clk);
    d_q.delete();
    for (int i = 0; i < 5; i++) begin
      words.push_back(32'hE0E0_0000 + DW'(i * 17));
      send(words[i]);
    end
    valid = 1'b0;
    drain();
    repeat (10) @(negedge clk);
    n_tests++;
    if (d_q.size() != words.size()) begin
      n_fail++;
      $display("FAIL e2e_count: got %0d words in slow domain, required %0d", d_q.size(), words.size());
    end else begin
      for (int i = 0; i < words.size(); i++) begin
        n_tests++;
        if (d_q[i] !== words[i]) begin
          n_fail++;
          $display("FAIL e2e_word: got %h at index %0d, required %h", d_q[i], i, words[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_flush();
    test_reset_mid_gap();
    test_end_to_end();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
